video_timing_gen: RTL

//  Programmable raster timing generator and successor to pixel_counters. It runs H/V counters

---
 rtl/video_timing_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with frame-boundary shadow config reload
module video_timing_gen #(
    parameter int CW = 12,
    parameter int DEF_HA = 1280,
    parameter int DEF_HF = 110,
    parameter int DEF_HS = 40,
    parameter int DEF_HB = 220,
    parameter int DEF_VA = 720,
    parameter int DEF_VF = 5,
    parameter int DEF_VS = 5,
    parameter int DEF_VB = 20,
    parameter bit DEF_HPOL = 1'b1,
    parameter bit DEF_VPOL = 1'b1,
    parameter bit STOP_MODE = 1'b0
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    input  logic          cfg_load,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [CW-1:0] ha, hf, hs, hb, va, vf, vs, vb;
        logic          hp, vp;
    } cfg_t;

    localparam cfg_t DEF = {CW'(DEF_HA), CW'(DEF_HF), CW'(DEF_HS), CW'(DEF_HB),
                            CW'(DEF_VA), CW'(DEF_VF), CW'(DEF_VS), CW'(DEF_VB),
                            DEF_HPOL, DEF_VPOL};

    function automatic logic [CW+1:0] ext(input logic [CW-1:0] x);
        return {2'b00, x};
    endfunction

    state_t        st, st_n;
    cfg_t          act, shd, cur, inc;
    logic [CW+1:0] in_ht, in_vt;
    logic [CW-1:0] h_last, v_last, h_adv, v_adv, h_n, v_n, hs_beg, vs_beg;
    logic          ok, load_ok, last_h, last_f, apply, run_n, h_in, v_in;

    assign inc = {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol};

    // Totals are summed two bits wider so an oversized line or frame is caught, not wrapped
    assign in_ht   = ext(inc.ha) + ext(inc.hf) + ext(inc.hs) + ext(inc.hb);
    assign in_vt   = ext(inc.va) + ext(inc.vf) + ext(inc.vs) + ext(inc.vb);
    assign ok      = (|inc.ha) && (|inc.hs) && (|inc.va) && (|inc.vs) &&
                     ~|in_ht[CW+1:CW] && ~|in_vt[CW+1:CW];
    assign load_ok = cfg_load && ok;

    assign h_last = act.ha + act.hf + act.hs + act.hb - CW'(1);
    assign v_last = act.va + act.vf + act.vs + act.vb - CW'(1);
    assign last_h = h_count == h_last;
    assign last_f = last_h && v_count == v_last;
    assign h_adv  = last_h ? '0 : h_count + CW'(1);
    assign v_adv  = last_h ? (v_count == v_last ? '0 : v_count + CW'(1)) : v_count;

    always_comb begin
        st_n  = IDLE;
        h_n   = '0;
        v_n   = '0;
        apply = 1'b0;
        if (st == IDLE) begin
            st_n  = enable ? RUN : IDLE;
            apply = enable;
        end else if (enable) begin
            st_n  = RUN;
            h_n   = h_adv;
            v_n   = v_adv;
            apply = last_f;
        end else if (STOP_MODE && !last_f) begin
            st_n = DRAIN;
            h_n  = h_adv;
            v_n  = v_adv;
        end
    end

    // Outputs are derived from the next counts and next config so they register in step
    assign cur    = apply ? shd : act;
    assign run_n  = st_n != IDLE;
    assign hs_beg = cur.ha + cur.hf;
    assign vs_beg = cur.va + cur.vf;
    assign h_in   = run_n && h_n >= hs_beg && h_n < hs_beg + cur.hs;
    assign v_in   = run_n && v_n >= vs_beg && v_n < vs_beg + cur.vs;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            h_count     <= '0;
            v_count     <= '0;
            act         <= DEF;
            shd         <= DEF;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            hsync       <= ~DEF_HPOL;
            vsync       <= ~DEF_VPOL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            st          <= st_n;
            h_count     <= h_n;
            v_count     <= v_n;
            act         <= cur;
            shd         <= load_ok ? inc : shd;
            cfg_pending <= load_ok || (cfg_pending && !apply);
            cfg_err     <= cfg_load && !ok;
            hsync       <= h_in ? cur.hp : ~cur.hp;
            vsync       <= v_in ? cur.vp : ~cur.vp;
            de          <= run_n && h_n < cur.ha && v_n < cur.va;
            line_start  <= run_n && h_n == '0;
            frame_start <= run_n && h_n == '0 && v_n == '0;
            running     <= run_n;
        end
    end
endmodule
